// File: rtl/mvma_pkg.sv
// Shared constants and types for the MVMA input-stream blocks.
// Frame layout is matrix (row-major), then bias b, then vector x.
package mvma_pkg;

    localparam int K       = 3;
    localparam int N_BEATS = K * K + 2 * K;

    localparam int M_BASE = 0;
    localparam int B_BASE = K * K;
    localparam int X_BASE = K * K + K;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    function automatic int frame_len(input int k);
        return k * k + 2 * k;
    endfunction

endpackage

// File: rtl/feeder_mem.sv
// Staging buffer for one frame: one write port (host), one registered read port (FSM).
// Contents are deliberately not reset so a frame survives a reset.
module feeder_mem #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 15,
    parameter int LOGSIZE = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LOGSIZE-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [LOGSIZE-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [0:SIZE-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mvma_stream_feeder.sv
// Serializes one staged frame (matrix, b, x) onto a valid/ready byte stream.
// Output register plus skid register sustain one beat per cycle across the read latency.
module mvma_stream_feeder #(
    parameter int K     = mvma_pkg::K,
    parameter int WIDTH = 8,
    parameter int LOGN  = $clog2(mvma_pkg::frame_len(K))
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [LOGN-1:0]         wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    start,
    input  logic                    clr_err,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_err,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output mvma_pkg::feeder_state_t dbg_state
);

    import mvma_pkg::*;

    localparam int N = frame_len(K);
    localparam logic [LOGN:0]   N_W       = (LOGN + 1)'(N);
    localparam logic [LOGN-1:0] LAST_BEAT = LOGN'(N - 1);

    // Handshake: a beat moves on any posedge with m_valid && m_ready. m_valid is a
    // register, never a function of m_ready, and m_valid/m_data hold until that beat moves.

    feeder_state_t    state, state_d;
    logic [LOGN:0]    rd_ptr;
    logic [LOGN-1:0]  beat_cnt;
    logic             rd_pend;
    logic             out_valid, skid_valid;
    logic [WIDTH-1:0] out_data, skid_data, rd_data;
    logic             pop, last_pop, issue, mem_we, set_err, room;
    logic [1:0]       occ_after;

    assign pop      = out_valid & m_ready;
    assign last_pop = pop && (beat_cnt == LAST_BEAT);

    // Entries still held after this edge, counting a read already in flight.
    assign occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
    assign room      = (occ_after < 2'd2) && (rd_ptr < N_W);

    feeder_mem #(
        .WIDTH  (WIDTH),
        .SIZE   (N),
        .LOGSIZE(LOGN)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_addr),
        .wdata(wr_data),
        .re   (issue),
        .raddr(rd_ptr[LOGN-1:0]),
        .rdata(rd_data)
    );

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        mem_we  = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    if ({1'b0, wr_addr} < N_W) mem_we  = 1'b1;
                    else                        set_err = 1'b1;
                end
                if (start) begin
                    state_d = PRIME;
                    issue   = 1'b1;
                end
            end
            PRIME: begin
                set_err = wr_en;
                issue   = room;
                state_d = STREAM;
            end
            STREAM: begin
                set_err = wr_en;
                issue   = room;
                if (last_pop) state_d = DONE;
            end
            DONE: begin
                set_err = wr_en;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state   <= state_d;
            rd_pend <= issue;
            if (state == DONE)  rd_ptr <= '0;
            else if (issue)     rd_ptr <= rd_ptr + 1'b1;
            if (state == DONE)  beat_cnt <= '0;
            else if (pop)       beat_cnt <= beat_cnt + 1'b1;
            if (set_err)        wr_err <= 1'b1;
            else if (clr_err)   wr_err <= 1'b0;
        end
    end

    // Read data lands in the output register when it is free (or draining with no
    // skid entry); otherwise it parks in the skid register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (last_pop) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (rd_pend) begin
            if (!out_valid || (pop && !skid_valid)) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_data  <= skid_data;
                skid_data <= rd_data;
            end else begin
                skid_data  <= rd_data;
                skid_valid <= 1'b1;
            end
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m_valid   = out_valid;
    assign m_data    = out_data;
    assign busy      = (state == PRIME) || (state == STREAM);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mvma_stream_feeder.sv
// Bench for mvma_stream_feeder: staged-frame model, expected-beat queue and a
// negedge monitor that checks every transferred beat and every stalled cycle.
module tb_mvma_stream_feeder;

    import mvma_pkg::*;

    localparam int W    = 8;
    localparam int N    = N_BEATS;
    localparam int LOGN = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [LOGN-1:0] wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            start = 1'b0;
    logic            clr_err = 1'b0;
    logic            m_ready = 1'b0;
    logic            busy, done, wr_err, m_valid;
    logic [W-1:0]    m_data;
    feeder_state_t   dbg_state;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_mem [N];
    logic         exp_err = 1'b0;
    int           ready_mode = 0;
    int           frame_beats = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    mvma_stream_feeder #(.K(3), .WIDTH(W), .LOGN(LOGN)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .clr_err  (clr_err),
        .busy     (busy),
        .done     (done),
        .wr_err   (wr_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ready driver: always-ready or coin flip per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", 32'(m_data), 32'(prev_data));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) check("extra_beat", 32'd0, 32'd1);
                    else                   check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
                    frame_beats++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    // driver tasks
    task automatic host_write(input int addr, input logic [W-1:0] d, input bit dut_idle);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = LOGN'(addr);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (dut_idle && addr < N) model_mem[addr] = d;
        else                      exp_err = 1'b1;
    endtask

    task automatic load_frame(input bit randomize_data);
        for (int i = 0; i < N; i++)
            host_write(i, randomize_data ? W'($urandom) : W'(i + 1), 1'b1);
    endtask

    task automatic queue_frame();
        frame_beats = 0;
        for (int i = 0; i < N; i++) exp_q.push_back(model_mem[i]);
    endtask

    task automatic start_frame();
        queue_frame();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check("wr_err_cleared", 32'(wr_err), 32'(exp_err));
    endtask

    // Called just after the edge that accepted start; returns on the done cycle.
    task automatic run_frame(input bit full_rate);
        int first_v = -1;
        int done_n  = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_prime", 32'(busy), 32'd1);
            if (first_v < 0 && m_valid) first_v = i;
            if (done) begin
                done_n = i;
                break;
            end
        end
        check("first_valid_cycle", 32'(first_v), 32'd2);
        if (done_n < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_busy_low", 32'(busy), 32'd0);
            check("done_valid_low", 32'(m_valid), 32'd0);
            check("frame_beats", 32'(frame_beats), 32'(N));
            if (full_rate) check("done_cycle", 32'(done_n), 32'(N + 2));
        end
    endtask

    task automatic bad_writes();
        @(posedge clk);
        @(posedge clk);
        host_write(0, 8'h55, 1'b0);
        host_write(N - 1, 8'hA5, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1 reset = 1'b1;

        // full-rate frame of 1..15
        load_frame(1'b0);
        ready_mode = 0;
        start_frame();
        run_frame(1'b1);
        check("wr_err_after_loads", 32'(wr_err), 32'(exp_err));

        // same frame under random backpressure
        ready_mode = 1;
        start_frame();
        run_frame(1'b0);

        // writes while streaming are dropped
        start_frame();
        fork
            run_frame(1'b0);
            bad_writes();
        join
        check("wr_err_busy_write", 32'(wr_err), 32'(exp_err));
        clear_err();
        host_write(N, 8'hAA, 1'b1);
        @(negedge clk);
        check("wr_err_oob_write", 32'(wr_err), 32'(exp_err));
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = LOGN'(N); clr_err = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        check("wr_err_set_wins", 32'(wr_err), 32'(exp_err));
        clear_err();
        start_frame();
        run_frame(1'b0);

        // random frames, random backpressure
        for (int f = 0; f < 3; f++) begin
            load_frame(1'b1);
            ready_mode = f % 2;
            start_frame();
            run_frame(ready_mode == 0);
        end

        // reset after the 6th handshake aborts the frame
        ready_mode = 0;
        start_frame();
        begin
            int waited = 0;
            while (frame_beats < 6 && waited < 200) begin
                @(posedge clk);
                waited++;
            end
            if (frame_beats < 6) check("abort_wait_timeout", 32'(frame_beats), 32'd6);
        end
        #1 reset = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        #1;
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        start_frame();
        run_frame(1'b1);

        // start during DONE is ignored, start the next cycle is taken
        start = 1'b1;
        queue_frame();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b0;
        run_frame(1'b1);
        check("wr_err_final", 32'(wr_err), 32'(exp_err));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
